// File: rtl/logic_gate_pipe_if.sv
// ============================================================================
// Module      : logic_gate_pipe_if
// Description : Operand/result handshake bundle for logic_gate_pipe.
//               Optional checker signals appear with LOGIC_GATE_PIPE_EXPCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logic_gate_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_parity;
    logic [CNT_W-1:0] xfer_cnt;
`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
    logic [WIDTH-1:0] exp_y;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, a, b, op, exp_y, out_ready,
        input  in_ready, out_valid, y, y_zero, y_parity, xfer_cnt, mismatch, err_cnt
    );

    modport slave (
        input  in_valid, a, b, op, exp_y, out_ready,
        output in_ready, out_valid, y, y_zero, y_parity, xfer_cnt, mismatch, err_cnt
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, y_zero, y_parity, xfer_cnt
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, y_zero, y_parity, xfer_cnt
    );
`endif
endinterface

`default_nettype wire

// File: rtl/logic_gate_pipe.sv
// ============================================================================
// Module      : logic_gate_pipe
// Description : Two-stage valid/ready pipelined bitwise logic unit with result
//               flags and transfer counter. Define LOGIC_GATE_PIPE_EXPCHK_EN
//               to add the expected-result checker (exp_y/mismatch/err_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    logic_gate_pipe_if.slave   bus
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;

    // Stage 2: result and flags
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_zero_q, y_zero_d;
    logic             y_parity_q, y_parity_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] y_calc;

    always_comb begin
        unique case (op_q)
            OP_AND:  y_calc = a_q & b_q;
            OP_OR:   y_calc = a_q | b_q;
            OP_NAND: y_calc = ~(a_q & b_q);
            OP_NOR:  y_calc = ~(a_q | b_q);
            OP_XOR:  y_calc = a_q ^ b_q;
            OP_XNOR: y_calc = ~(a_q ^ b_q);
            OP_NOTA: y_calc = ~a_q;
            default: y_calc = a_q;
        endcase
    end

    // in_ready depends on out_ready but never on in_valid
    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign accept = bus.in_valid && s1_adv;
    assign xfer   = out_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_zero_d    = y_zero_q;
        y_parity_d  = y_parity_q;
        xfer_cnt_d  = xfer_cnt_q;

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (accept) begin
            a_d  = bus.a;
            b_d  = bus.b;
            op_d = bus.op;
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d        = y_calc;
                y_zero_d   = (y_calc == '0);
                y_parity_d = ^y_calc;
            end
        end
        if (xfer) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_zero_q    <= 1'b1;
            y_parity_q  <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_zero_q    <= y_zero_d;
            y_parity_q  <= y_parity_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_zero    = y_zero_q;
    assign bus.y_parity  = y_parity_q;
    assign bus.xfer_cnt  = xfer_cnt_q;

`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
    // Expected value rides alongside the operands; the flag is loaded with the result
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;
        if (accept) begin
            exp_d = bus.exp_y;
        end
        if (s2_adv) begin
            mismatch_d = s1_valid_q && (y_calc != exp_q);
        end
        if (xfer && mismatch_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
// ============================================================================
// Module      : tb_logic_gate_pipe
// Description : Scoreboard bench for logic_gate_pipe (WIDTH=8, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_gate_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       p;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    res_t sb[$];
    logic [CNT_W-1:0] cnt_m;
    logic [CNT_W-1:0] snap;
    logic             use_force;
    logic [7:0]       exp_force;

    logic_gate_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w);
        case (o)
            3'd0:    return x & w;
            3'd1:    return x | w;
            3'd2:    return ~(x & w);
            3'd3:    return ~(x | w);
            3'd4:    return x ^ w;
            3'd5:    return ~(x ^ w);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer
    always @(negedge clk) begin
        res_t e;
        logic [7:0] r;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                r = f_model(bus.op, bus.a, bus.b);
                sb.push_back({r, (r == 8'h00), ^r});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_y", 64'(bus.y), 64'(e.y));
                    check_val("sb_zero", 64'(bus.y_zero), 64'(e.z));
                    check_val("sb_parity", 64'(bus.y_parity), 64'(e.p));
                end
                check_val("sb_xfer_cnt", 64'(bus.xfer_cnt), 64'(cnt_m));
                cnt_m = cnt_m + 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = w;
`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
        bus.exp_y = use_force ? exp_force : f_model(o, x, w);
`endif
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        n_checks = 0;
        n_fail   = 0;
        cnt_m    = '0;
        use_force = 1'b0;
        exp_force = 8'h00;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
        bus.exp_y = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_y", 64'(bus.y), 64'd0);
        check_val("rst_y_zero", 64'(bus.y_zero), 64'd1);
        check_val("rst_y_parity", 64'(bus.y_parity), 64'd0);
        check_val("rst_xfer_cnt", 64'(bus.xfer_cnt), 64'd0);
`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
        check_val("rst_mismatch", 64'(bus.mismatch), 64'd0);
        check_val("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // NOR latency
        send(3'b011, 8'h0F, 8'h30);
        @(negedge clk);
        check_val("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_val("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        check_val("nor_y", 64'(bus.y), 64'hC0);
        check_val("nor_zero", 64'(bus.y_zero), 64'd0);
        check_val("nor_parity", 64'(bus.y_parity), 64'd0);
        @(posedge clk);
        #1;

        // NAND then XOR back-to-back
        send(3'b010, 8'hFF, 8'hFF);
        send(3'b100, 8'hA5, 8'h5A);
        @(negedge clk);
        check_val("b2b_y0", 64'(bus.y), 64'h00);
        check_val("b2b_zero0", 64'(bus.y_zero), 64'd1);
        @(negedge clk);
        check_val("b2b_valid1", 64'(bus.out_valid), 64'd1);
        check_val("b2b_y1", 64'(bus.y), 64'hFF);
        check_val("b2b_parity1", 64'(bus.y_parity), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: two accepted, third blocked, y held
        snap = cnt_m;
        bus.out_ready = 1'b0;
        send(3'b000, 8'h3C, 8'h0F);
        send(3'b101, 8'h12, 8'h34);
        bus.in_valid = 1'b1;
        bus.op = 3'b110;
        bus.a  = 8'h81;
        bus.b  = 8'h00;
`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
        bus.exp_y = 8'h7E;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check_val("stall_held_y", 64'(bus.y), 64'h0C);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("unstall_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        check_val("stall_xfer_cnt", 64'(bus.xfer_cnt), 64'(snap + 4'd3));

        // 16 transfers wrap the 4-bit counter
        snap = cnt_m;
        for (int i = 0; i < 16; i++) send(3'(i % 8), 8'(i * 37), 8'(i * 11 + 5));
        drain();
        check_val("cnt_wrap", 64'(bus.xfer_cnt), 64'(snap));

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset with two results in flight
        bus.out_ready = 1'b0;
        send(3'b001, 8'h11, 8'h22);
        send(3'b111, 8'h55, 8'h00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("async_rst_xfer", 64'(bus.xfer_cnt), 64'd0);
        check_val("async_rst_y", 64'(bus.y), 64'd0);
        sb.delete();
        cnt_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("no_stale_valid", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

`ifdef LOGIC_GATE_PIPE_EXPCHK_EN
        use_force = 1'b1;
        exp_force = 8'h07;
        send(3'b001, 8'h01, 8'h02);
        @(negedge clk);
        @(negedge clk);
        check_val("chk_mismatch_hi", 64'(bus.mismatch), 64'd1);
        @(negedge clk);
        check_val("chk_err_cnt1", 64'(bus.err_cnt), 64'd1);
        @(posedge clk);
        #1;
        exp_force = 8'h03;
        send(3'b001, 8'h01, 8'h02);
        @(negedge clk);
        @(negedge clk);
        check_val("chk_mismatch_lo", 64'(bus.mismatch), 64'd0);
        @(negedge clk);
        check_val("chk_err_cnt_hold", 64'(bus.err_cnt), 64'd1);
        @(posedge clk);
        #1;
        use_force = 1'b0;
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (1..64).
REQ-002 SHALL have parameter CNT_W, default 16, transfer-counter width in bits (2..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  3  operation select, captured with a and b.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port y  output  WIDTH  result.
REQ-013 SHALL have port y_zero  output  1  y is all zeros.
REQ-014 SHALL have port y_parity  output  1  XOR-reduction of y.
REQ-015 SHALL have port xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-016 SHALL decode op: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 pass a; bitwise over WIDTH.
REQ-017 SHALL accept an input when in_valid && in_ready at the clock edge; output transfer when out_valid && out_ready.
REQ-018 SHALL be a two-stage pipeline: stage 1 registers a, b, op; stage 2 registers y, y_zero, y_parity from stage-1 contents.
REQ-019 SHALL present a result on out_valid exactly 2 cycles after acceptance when out_ready stays high.
REQ-020 SHALL sustain one transfer per cycle with out_ready held high.
REQ-021 SHALL advance stage 2 when stage 2 empty or out_ready high; stage 1 advances when stage 1 empty or stage 2 advances.
REQ-022 SHALL drive in_ready = !stage1_valid || stage2_advance (combinational from out_ready permitted; no combinational path from in_valid).
REQ-023 SHALL hold y, y_zero, y_parity stable while out_valid && !out_ready.
REQ-024 SHALL preserve order and never drop or duplicate a result; at most 2 results in flight.
REQ-025 SHALL increment xfer_cnt by 1 on each output transfer, wrapping from all-ones to 0.
REQ-026 SHALL treat simultaneous input accept and output transfer in the same cycle as both occurring (pipeline remains full).

Reset
REQ-027 SHALL, on rst_n low, immediately clear both stage valids, y, y_zero-source register, y_parity, xfer_cnt; out_valid=0, y=0, y_zero=1, y_parity=0, xfer_cnt=0.
REQ-028 SHALL discard in-flight results on reset mid-operation; in_ready=1 from the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro LOGIC_GATE_PIPE_EXPCHK_EN defined, add input exp_y (WIDTH, carried with operands), output mismatch (1, registered, high on the transfer cycle when y != carried exp_y) and output err_cnt (CNT_W, saturating count of mismatches); both reset to 0.
REQ-030 SHALL, without LOGIC_GATE_PIPE_EXPCHK_EN, omit exp_y, mismatch, err_cnt and all related logic.

Verification
REQ-031 SHALL cover: WIDTH=8, op=011, a=8'h0F, b=8'h30, out_ready=1 -> y=8'hC0, y_zero=0, y_parity=0, out_valid 2 cycles after accept.
REQ-032 SHALL cover: op=010, a=b=8'hFF, then op=100, a=8'hA5, b=8'h5A back-to-back -> y=8'h00 (y_zero=1) then y=8'hFF (y_parity=0) on consecutive cycles.
REQ-033 SHALL cover: out_ready=0 for 5 cycles, 3 sets offered -> 2 accepted, in_ready=0 thereafter, y held; out_ready=1 -> 3 results in order, xfer_cnt=3.
REQ-034 SHALL cover: CNT_W=4, 16 back-to-back transfers -> xfer_cnt returns to 0.
REQ-035 SHALL cover: rst_n pulsed low with 2 results in flight -> out_valid=0, xfer_cnt=0 asynchronously, no stale result after release.
REQ-036 SHALL cover (EXPCHK_EN): op=001, a=8'h01, b=8'h02, exp_y=8'h07 -> mismatch=1, err_cnt=1; exp_y=8'h03 -> mismatch=0.
